mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter on the processor's store-write bus, in parallel with `memory_map`. It snoops the same write-enable/address/data signals and claims two word addresses directly above the `memory_map` window. Accepted bytes are buffered in a small FIFO and serialised 8N1, LSB first, on a single `tx` line. Status outputs report activity, FIFO fill and overflow for debug and LED use.

## Interface
- `BASE_ADDR`, 32'h00004014: TXDATA register address; DIVISOR is at `BASE_ADDR+4`.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, ≥2.
- `DIV_RESET`, 16: reset value of the bit-period divisor, in clocks per bit.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Write_Ena`  in  1  store strobe from the MEM stage, one cycle per store.
- `Write_addr`  in  32  store word address.
- `Write_data`  in  32  store data.
- `tx`  out  1  serial output; idle high.
- `tx_busy`  out  1  high whenever the FSM is not IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.
- `overflow`  out  1  sticky; set when a TXDATA write is dropped because the FIFO is full.

## Operation
- Decode: the block acts only when `Write_Ena`=1 and `Write_addr` matches a register address exactly. All other writes are ignored.
- TXDATA write: pushes `Write_data[7:0]` into the FIFO. Upper bits are ignored.
- DIVISOR write: loads `Write_data[15:0]`. A value of 0 is stored as 1.
- FIFO full is evaluated before any same-cycle pop. A push while full is dropped, the FIFO contents are unchanged, and `overflow` is set. `overflow` clears only on reset.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, latch the divisor into the bit timer, and go to START.
  - START: `tx`=0 for one bit period, then go to DATA.
  - DATA: output bits 0..7, one bit period each, then go to STOP.
  - STOP: `tx`=1 for one bit period. If the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Bit timer counts latched-divisor−1 down to 0. A DIVISOR write mid-frame takes effect at the next pop.
- Simultaneous push and pop on a non-full FIFO: both occur, and `fifo_count` is unchanged.
- Reset values:
  - `tx`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0.
  - FSM in IDLE, divisor=`DIV_RESET`, FIFO empty.
- Reset mid-frame aborts the frame: `tx` returns high asynchronously and the queued bytes are discarded.

## Timing
- `tx` is a registered output with no combinational path from the inputs.
- Write at edge k into an empty FIFO with the FSM in IDLE:
  - `fifo_count`=1 after edge k.
  - Pop and START entry at edge k+1, so `tx` falls after edge k+1.
- One frame is exactly 10×N clocks for divisor N. Back-to-back frames are contiguous.
- `tx_busy` rises with the falling edge of the start bit. It falls one cycle after the last stop-bit clock when the FIFO is empty.
- Sustained throughput is one byte per 10N clocks. A software store rate above this overflows after the FIFO's `FIFO_DEPTH` bytes of slack are used.

## Structure
- Shared package `mmio_pkg` holds:
  - MMIO address constants: `memory_map` window 0x4000–0x4010, UART TXDATA/DIVISOR.
  - The UART FSM state enum (IDLE, START, DATA, STOP).
- Sub-module `sync_fifo`: parameterised width and depth, with push/pop/full/empty/count. Full is evaluated pre-pop. It is reusable by later MMIO peripherals.
- The top level contains the address decode, divisor register, FSM, bit timer, bit index counter and shift register.

## Test plan
- **Reset state:** assert `rst` mid-simulation → `tx`=1, `tx_busy`=0, `fifo_count`=0 and `overflow`=0 immediately, without waiting for a clock.
- **Single byte:** DIVISOR←4, then TXDATA←0x000000A5 → `tx` falls one cycle after the write edge. Expected `tx` sequence, 4 clocks per bit: 0, 1,0,1,0,0,1,0,1, 1. `tx_busy` lasts 40 cycles.
- **Back-to-back and full FIFO:** DIVISOR←2, then five consecutive TXDATA writes 0x11..0x15.
  - `fifo_count` peaks at 4.
  - No overflow, because 0x11 is popped before the 5th write.
  - Five contiguous 20-cycle frames with no idle gap.
- **Overflow:** DIVISOR←100 and fill the FIFO. One further TXDATA write 0x99 → `overflow`=1, `fifo_count` stays 4, and 0x99 never appears on `tx`.
- **Decode isolation:** writes to 0x4000, 0x4010 and 0x401C, plus a write to `BASE_ADDR` with `Write_Ena`=0 → no FIFO or divisor change.
- **Mid-frame divisor change:** DIVISOR←0 during a frame → the current frame keeps the old N, the next frame uses 1 clock per bit, and `tx` toggles every clock for alternating data 0x55.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: the address map seen on the store-write bus and the
// UART transmitter state encoding.
package mmio_pkg;

    localparam logic [31:0] MEM_MAP_BASE      = 32'h0000_4000;
    localparam logic [31:0] MEM_MAP_LAST      = 32'h0000_4010;
    localparam logic [31:0] UART_TXDATA_ADDR  = 32'h0000_4014;
    localparam logic [31:0] UART_DIVISOR_ADDR = 32'h0000_4018;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    // A zero divisor would make the bit timer wrap, so it is promoted to one.
    function automatic logic [15:0] sanitize_divisor(input logic [15:0] value);
        return (value == 16'd0) ? 16'd1 : value;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full and empty are judged on the
// current contents, so a push while full is dropped even if a pop happens too.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers rely on DEPTH being a power of two so they wrap naturally.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the store-write bus: TXDATA
// queues a byte, DIVISOR sets clocks per bit for frames started afterwards.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = UART_TXDATA_ADDR,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd16,
    localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Write_Ena,
    input  logic [31:0]   Write_addr,
    input  logic [31:0]   Write_data,
    output logic          tx,
    output logic          tx_busy,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    logic        wr_txdata, wr_divisor;
    logic        fifo_full, fifo_empty, fifo_pop;
    logic [7:0]  fifo_head;
    logic [15:0] divisor_q, divisor_d;
    logic        overflow_q, overflow_d;
    logic        bit_done;
    logic        unused_upper;

    uart_state_e state_q;
    logic [15:0] bit_len_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;

    assign unused_upper = ^Write_data[31:16];

    // The FSM takes the next byte either from IDLE or at the very end of a stop bit.
    always_comb begin
        wr_txdata  = Write_Ena && (Write_addr == BASE_ADDR);
        wr_divisor = Write_Ena && (Write_addr == BASE_ADDR + 32'd4);
        divisor_d  = wr_divisor ? sanitize_divisor(Write_data[15:0]) : divisor_q;
        overflow_d = overflow_q || (wr_txdata && fifo_full);
        bit_done   = (timer_q == 16'd0);
        fifo_pop   = !fifo_empty &&
                     ((state_q == UART_IDLE) || ((state_q == UART_STOP) && bit_done));
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_txdata),
        .push_data (Write_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor_q  <= DIV_RESET;
            overflow_q <= 1'b0;
        end else begin
            divisor_q  <= divisor_d;
            overflow_q <= overflow_d;
        end
    end

    // bit_len_q freezes the divisor for the whole frame; timer counts it down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UART_IDLE;
            bit_len_q <= '0;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                UART_IDLE: begin
                    if (fifo_pop) begin
                        shift_q   <= fifo_head;
                        bit_len_q <= divisor_q - 16'd1;
                        timer_q   <= divisor_q - 16'd1;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= UART_START;
                    end
                end
                UART_START: begin
                    if (bit_done) begin
                        timer_q   <= bit_len_q;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= UART_DATA;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                UART_DATA: begin
                    if (bit_done) begin
                        timer_q <= bit_len_q;
                        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                            tx_q    <= 1'b1;
                            state_q <= UART_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                UART_STOP: begin
                    if (bit_done) begin
                        if (fifo_pop) begin
                            shift_q   <= fifo_head;
                            bit_len_q <= divisor_q - 16'd1;
                            timer_q   <= divisor_q - 16'd1;
                            tx_q      <= 1'b0;
                            state_q   <= UART_START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= UART_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= UART_IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign overflow = overflow_q;

endmodule
